// File: rtl/hadamard4_seq_ctrl.sv
// hadamard4_seq_ctrl
// Frame sequencer for the 4-point systolic Hadamard array. It accepts one
// 4-sample vector and holds it on arr_x*. It then raises arr_start for LAT
// cycles, captures arr_y* on the LAT-th edge and offers the result on a
// valid/ready output port.
// Optional feature: define HADAMARD_SEQ_FRAME_CNT_EN to add frame_cnt[15:0],
// which counts completed output transfers.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high. A source holds valid and its data until that edge. The input side
// offers ready combinationally, and in the DONE state it does so only while the
// consumer is taking the result, which lets a new frame start with no bubble.

module hadamard4_seq_ctrl #(
    parameter int W   = 9,
    parameter int LAT = 8,
    parameter int CW  = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_x0,
    input  logic [W-1:0] in_x1,
    input  logic [W-1:0] in_x2,
    input  logic [W-1:0] in_x3,
    output logic         arr_start,
    output logic [W-1:0] arr_x0,
    output logic [W-1:0] arr_x1,
    output logic [W-1:0] arr_x2,
    output logic [W-1:0] arr_x3,
    input  logic [W-1:0] arr_y0,
    input  logic [W-1:0] arr_y1,
    input  logic [W-1:0] arr_y2,
    input  logic [W-1:0] arr_y3,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_y0,
    output logic [W-1:0] out_y1,
    output logic [W-1:0] out_y2,
    output logic [W-1:0] out_y3,
    output logic         busy,
`ifdef HADAMARD_SEQ_FRAME_CNT_EN
    output logic [15:0]  frame_cnt,
`endif
    output logic [1:0]   state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter value in the last RUN cycle; the capture happens on the edge that ends it.
    localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          accept;

    // Ready while idle, or in DONE while the result leaves; never during flush or reset.
    assign in_ready  = ~rst & ~flush &
                       ((state == S_IDLE) | ((state == S_DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign state_dbg = state;

    // Sequencer FSM: load vector, run the array for LAT cycles, hold result until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            arr_start <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            arr_x0    <= '0;
            arr_x1    <= '0;
            arr_x2    <= '0;
            arr_x3    <= '0;
            out_y0    <= '0;
            out_y1    <= '0;
            out_y2    <= '0;
            out_y3    <= '0;
        end else if (flush) begin
            // Abort: drop any in-flight or captured frame, keep arr_x* and cnt.
            state     <= S_IDLE;
            arr_start <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        arr_x0    <= in_x0;
                        arr_x1    <= in_x1;
                        arr_x2    <= in_x2;
                        arr_x3    <= in_x3;
                        cnt       <= '0;
                        state     <= S_RUN;
                        arr_start <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        out_y0    <= arr_y0;
                        out_y1    <= arr_y1;
                        out_y2    <= arr_y2;
                        out_y3    <= arr_y3;
                        state     <= S_DONE;
                        arr_start <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (accept) begin
                            // Back-to-back: the next vector loads as the result leaves.
                            arr_x0    <= in_x0;
                            arr_x1    <= in_x1;
                            arr_x2    <= in_x2;
                            arr_x3    <= in_x3;
                            cnt       <= '0;
                            state     <= S_RUN;
                            arr_start <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    arr_start <= 1'b0;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef HADAMARD_SEQ_FRAME_CNT_EN
    // Count completed output transfers; a flush cycle never counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (!flush && out_valid && out_ready) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hadamard4_seq_ctrl.sv
// tb_hadamard4_seq_ctrl
// Self-checking bench for hadamard4_seq_ctrl. It contains a behavioural array
// model: natural-order H4 of arr_x*, presented during the LAT-th start cycle
// and random garbage otherwise. A negedge monitor compares the DUT against
// expected results queued at acceptance time.

module tb_hadamard4_seq_ctrl;

    localparam int W   = 9;
    localparam int LAT = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_x0, in_x1, in_x2, in_x3;
    logic         arr_start;
    logic [W-1:0] arr_x0, arr_x1, arr_x2, arr_x3;
    logic [W-1:0] arr_y0, arr_y1, arr_y2, arr_y3;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_y0, out_y1, out_y2, out_y3;
    logic         busy;
    logic [1:0]   state_dbg;
`ifdef HADAMARD_SEQ_FRAME_CNT_EN
    logic [15:0]  frame_cnt;
`endif

    hadamard4_seq_ctrl #(.W(W), .LAT(LAT), .CW(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x0(in_x0), .in_x1(in_x1), .in_x2(in_x2), .in_x3(in_x3),
        .arr_start(arr_start),
        .arr_x0(arr_x0), .arr_x1(arr_x1), .arr_x2(arr_x2), .arr_x3(arr_x3),
        .arr_y0(arr_y0), .arr_y1(arr_y1), .arr_y2(arr_y2), .arr_y3(arr_y3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y0(out_y0), .out_y1(out_y1), .out_y2(out_y2), .out_y3(out_y3),
        .busy(busy),
`ifdef HADAMARD_SEQ_FRAME_CNT_EN
        .frame_cnt(frame_cnt),
`endif
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Natural-order 4-point Hadamard transform, packed {y3,y2,y1,y0}.
    function automatic logic [4*W-1:0] h4(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c, input logic [W-1:0] d);
        int x0, x1, x2, x3;
        int y0, y1, y2, y3;
        x0 = int'($signed(a));
        x1 = int'($signed(b));
        x2 = int'($signed(c));
        x3 = int'($signed(d));
        y0 = x0 + x1 + x2 + x3;
        y1 = x0 - x1 + x2 - x3;
        y2 = x0 + x1 - x2 - x3;
        y3 = x0 - x1 - x2 + x3;
        return {W'(y3), W'(y2), W'(y1), W'(y0)};
    endfunction

    // ---------------- array model ----------------
    int           run_cyc;
    logic [4*W-1:0] garb;
    logic [4*W-1:0] y_good;

    always @(posedge clk or posedge rst) begin
        if (rst || !arr_start) run_cyc <= 0;
        else                   run_cyc <= run_cyc + 1;
    end

    always @(posedge clk) garb <= (4*W)'({$urandom, $urandom});

    always_comb begin
        y_good = h4(arr_x0, arr_x1, arr_x2, arr_x3);
        {arr_y3, arr_y2, arr_y1, arr_y0} = (arr_start && run_cyc >= LAT - 1) ? y_good : garb;
    end

    // ---------------- scoreboard / monitor ----------------
    logic [4*W-1:0] exp_q[$];
    int             acc_q[$];
    logic           ov_prev    = 1'b0;
    logic           flush_prev = 1'b0;
    int             start_cnt  = 0;
    int             exp_frames = 0;

    always @(negedge clk) begin
        logic xfer;
        logic acc;
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            ov_prev    = 1'b0;
            flush_prev = 1'b0;
            start_cnt  = 0;
            exp_frames = 0;
        end else begin
            xfer = out_valid && out_ready && !flush;
            acc  = in_valid && in_ready;
            check("in_ready", in_ready, !flush && (!busy || (out_valid && out_ready)));
            check("busy", busy, arr_start || out_valid);
            if (out_valid) check("start_low_in_done", arr_start, 1'b0);
            if (flush_prev) check("flush_to_idle", {busy, out_valid, arr_start}, 3'b000);
            if (arr_start) start_cnt++;
            if (out_valid && !ov_prev) begin
                if (acc_q.size() == 0) begin
                    check("out_valid_unexpected", out_valid, 1'b0);
                end else begin
                    check("latency", cyc - (acc_q[0] + 1), LAT);
                    check("start_cycles", start_cnt, LAT);
                end
            end
            if (out_valid && exp_q.size() != 0)
                check("out_y", {out_y3, out_y2, out_y1, out_y0}, exp_q[0]);
`ifdef HADAMARD_SEQ_FRAME_CNT_EN
            check("frame_cnt", frame_cnt, exp_frames[15:0]);
`endif
            if (xfer && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
                exp_frames++;
            end
            if (flush && busy) begin
                exp_q.delete();
                acc_q.delete();
            end
            if (acc) begin
                exp_q.push_back(h4(in_x0, in_x1, in_x2, in_x3));
                acc_q.push_back(cyc);
                start_cnt = 0;
            end
            ov_prev    = out_valid;
            flush_prev = flush;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_x(input int a, input int b, input int c, input int d);
        in_x0 = W'(a);
        in_x1 = W'(b);
        in_x2 = W'(c);
        in_x3 = W'(d);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        set_x(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Present a vector and hold it until accepted; returns at accept edge + 1,
    // with in_valid still high so a caller can chain frames back-to-back.
    task automatic send(input int a, input int b, input int c, input int d);
        logic got;
        got = 1'b0;
        set_x(a, b, c, d);
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            if (got) break;
        end
        check("send_accepted", got, 1'b1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        check("drain", exp_q.size(), 0);
        check("drain_idle", busy, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_arr_start"}, arr_start, 1'b0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_in_ready"}, in_ready, 1'b0);
        check({tag, "_arr_x"}, {arr_x3, arr_x2, arr_x1, arr_x0}, '0);
        check({tag, "_out_y"}, {out_y3, out_y2, out_y1, out_y0}, '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic acc;
        int   a, b, c, d;

        rst = 1'b1;
        #1 check_all_zero("reset");
        do_reset();
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // T1 single frame
        send(3, 4, -2, 1);
        in_valid = 1'b0;
        wait_drain();

        // T2 back-to-back with in_valid held
        @(posedge clk);
        #1;
        send(3, 4, -2, 1);
        send(-1, 6, 2, 4);
        in_valid = 1'b0;
        wait_drain();

        // T3 backpressure
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(5, -3, 1, 0);
        in_valid = 1'b0;
        repeat (LAT + 20) @(posedge clk);
        @(negedge clk);
        check("bp_out_valid", out_valid, 1'b1);
        check("bp_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain();

        // T4 flush in the fourth RUN cycle, then resend
        @(posedge clk);
        #1;
        send(-2, -3, -1, -5);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            check("no_ov_after_flush", out_valid, 1'b0);
        end
        check("arr_x_kept", {arr_x3, arr_x2, arr_x1, arr_x0},
              {W'(-5), W'(-1), W'(-3), W'(-2)});
        @(posedge clk);
        #1;
        send(-2, -3, -1, -5);
        in_valid = 1'b0;
        wait_drain();

        // T5 reset in the middle of RUN
        @(posedge clk);
        #1;
        send(3, 4, -2, 1);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("midrun_reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send(3, 4, -2, 1);
        in_valid = 1'b0;
        wait_drain();

        // Randomized traffic with random backpressure and occasional flush
        @(posedge clk);
        #1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 2) != 0);
                a = int'($urandom_range(0, 127)) - 64;
                b = int'($urandom_range(0, 127)) - 64;
                c = int'($urandom_range(0, 127)) - 64;
                d = int'($urandom_range(0, 127)) - 64;
                set_x(a, b, c, d);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 49) == 0);
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Bound the whole run.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end

endmodule
